// File: rtl/wb_stage_queued_pkg.sv
// Shared constants and types for the queued write-back stage.
package wb_stage_queued_pkg;

   localparam int unsigned WB_WORD_WIDTH     = 32;
   localparam int unsigned WB_REG_FILE_DEPTH = 4;

   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_WAIT_MEM = 2'd2
   } wb_state_e;

   // Per-entry control fields kept alongside dest and alu_res in the queue.
   typedef struct packed {
      logic       wb_en;
      logic       mem_r_en;
      logic [1:0] size;
      logic       is_signed;
      logic [1:0] addr_lo;
   } wb_ctrl_t;

endpackage

// File: rtl/wb_load_align.sv
// Lane select and sign/zero extension of a little-endian load word.
module wb_load_align
   import wb_stage_queued_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = WB_WORD_WIDTH
) (
   input  logic [WORD_WIDTH-1:0] data,
   input  logic [1:0]            size,
   input  logic                  is_signed,
   input  logic [1:0]            addr_lo,
   output logic [WORD_WIDTH-1:0] value
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c = 8'(data >> {addr_lo, 3'b000});
      half_c = 16'(data >> {addr_lo[1], 4'b0000});
      value  = data;
      case (size)
         LD_BYTE: value = {{(WORD_WIDTH-8){is_signed & byte_c[7]}}, byte_c};
         LD_HALF: value = {{(WORD_WIDTH-16){is_signed & half_c[15]}}, half_c};
         default: value = data;
      endcase
   end

endmodule

// File: rtl/wb_stage_queued.sv
// Write-back stage: in-order retire queue with load-data wait and a registered
// register-file write port.
module wb_stage_queued
   import wb_stage_queued_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = WB_WORD_WIDTH,
   parameter int unsigned DEST_WIDTH = WB_REG_FILE_DEPTH,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wb_en,
   input  logic                  in_mem_r_en,
   input  logic [1:0]            in_size,
   input  logic                  in_signed,
   input  logic [1:0]            in_addr_lo,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic [WORD_WIDTH-1:0] in_alu_res,
   input  logic                  mem_rsp_valid,
   input  logic [WORD_WIDTH-1:0] mem_rsp_data,
   output logic                  WB_EN_out,
   output logic [DEST_WIDTH-1:0] WB_Dest,
   output logic [WORD_WIDTH-1:0] WB_Value,
   output logic                  busy,
   output logic                  rsp_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_ctrl_t              ctrl_q [DEPTH];
   logic [DEST_WIDTH-1:0] dest_q [DEPTH];
   logic [WORD_WIDTH-1:0] alu_q  [DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nx;
   logic [CNT_W-1:0] count, count_nx, remain_c;
   wb_state_e        state, state_nx;

   wb_ctrl_t              in_ctrl, head_ctrl, nh_ctrl;
   logic                  push_c, retire_c;
   logic [WORD_WIDTH-1:0] load_val_c, value_c;

   assign in_ctrl = '{wb_en:     in_wb_en,
                      mem_r_en:  in_mem_r_en,
                      size:      in_size,
                      is_signed: in_signed,
                      addr_lo:   in_addr_lo};

   assign head_ctrl = ctrl_q[rd_ptr];
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign busy      = (count != '0);
   assign push_c    = in_valid && in_ready;
   assign retire_c  = (state == ST_RUN) || ((state == ST_WAIT_MEM) && mem_rsp_valid);

   wb_load_align #(.WORD_WIDTH(WORD_WIDTH)) u_align (
      .data      (mem_rsp_data),
      .size      (head_ctrl.size),
      .is_signed (head_ctrl.is_signed),
      .addr_lo   (head_ctrl.addr_lo),
      .value     (load_val_c)
   );

   assign value_c = (state == ST_WAIT_MEM) ? load_val_c : alu_q[rd_ptr];

   // Next head comes from the incoming entry when nothing else remains queued.
   always_comb begin
      rd_ptr_nx = rd_ptr;
      remain_c  = count;
      nh_ctrl   = in_ctrl;
      state_nx  = ST_IDLE;
      if (retire_c) begin
         rd_ptr_nx = rd_ptr + PTR_W'(1);
         remain_c  = count - CNT_W'(1);
      end
      count_nx = remain_c + CNT_W'(push_c);
      if (remain_c != '0)
         nh_ctrl = ctrl_q[rd_ptr_nx];
      if (count_nx != '0)
         state_nx = nh_ctrl.mem_r_en ? ST_WAIT_MEM : ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         ctrl_q[wr_ptr] <= in_ctrl;
         dest_q[wr_ptr] <= in_dest;
         alu_q[wr_ptr]  <= in_alu_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         state     <= ST_IDLE;
         WB_EN_out <= 1'b0;
         WB_Dest   <= '0;
         WB_Value  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (push_c)
            wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr    <= rd_ptr_nx;
         count     <= count_nx;
         state     <= state_nx;
         WB_EN_out <= retire_c && head_ctrl.wb_en;
         if (retire_c) begin
            WB_Dest  <= dest_q[rd_ptr];
            WB_Value <= value_c;
         end
         if (mem_rsp_valid && (state != ST_WAIT_MEM))
            rsp_err <= 1'b1;
      end
   end

endmodule
